// File: rtl/shift_op_sequencer.sv
// Command sequencer for an external 8-bit load/rotate/arith-shift-right register.
// Takes one command over valid/ready, steps the register controls, and pulses done when sr_q is final.
module shift_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amount,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] sr_q,
    output logic             sr_parallel_loadn,
    output logic             sr_rotate_right,
    output logic             sr_as_right,
    output logic [WIDTH-1:0] sr_data_in,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | ready for a command, register reloads its own value
    // LOAD  | one cycle driving the latched load value into the register
    // SHIFT | one register shift per cycle until the remaining count runs out
    // DONE  | sr_q is final, done pulses, register held
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROL  = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            remaining <= '0;
            op_q      <= OP_LOAD;
            data_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data;
                        if (cmd_op == OP_LOAD) begin
                            state <= LOAD;
                        end else if (cmd_amount == '0) begin
                            state <= DONE;
                        end else begin
                            remaining <= cmd_amount;
                            state     <= SHIFT;
                        end
                    end
                end
                LOAD: state <= DONE;
                SHIFT: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The register has no hold mode, so every non-shift state reloads sr_q into itself.
    always_comb begin
        cmd_ready         = 1'b0;
        done              = 1'b0;
        sr_parallel_loadn = 1'b0;
        sr_rotate_right   = 1'b0;
        sr_as_right       = 1'b0;
        sr_data_in        = sr_q;
        case (state)
            IDLE: cmd_ready = 1'b1;
            LOAD: sr_data_in = data_q;
            SHIFT: begin
                sr_parallel_loadn = 1'b1;
                case (op_q)
                    OP_ROR: sr_rotate_right = 1'b1;
                    OP_ASR: begin
                        sr_rotate_right = 1'b1;
                        sr_as_right     = 1'b1;
                    end
                    default: sr_rotate_right = 1'b0;
                endcase
            end
            DONE: done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign busy = ~cmd_ready;

endmodule
